// File: rtl/pc_seq_unit_if.sv
// Fetch-head bus for pc_seq_unit: decode-side controls in, current PC and
// return-address-stack status out.
interface pc_seq_unit_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             ena;
  logic [2:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output ena, mode, data_in,
    input  data_out, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  ena, mode, data_in,
    output data_out, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: next-PC generation (inc/branch/jump/exception)
// plus a circular return-address stack for call/return.
module pc_seq_unit #(
  parameter int                   WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VEC = '0,
  parameter logic [WIDTH-1:0]     EXC_VEC   = WIDTH'(4),
  parameter int                   STEP      = 4,
  parameter int                   RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  pc_seq_unit_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_INC    = 3'b001;
  localparam logic [2:0] MODE_BRANCH = 3'b010;
  localparam logic [2:0] MODE_JUMP   = 3'b011;
  localparam logic [2:0] MODE_CALL   = 3'b100;
  localparam logic [2:0] MODE_RET    = 3'b101;
  localparam logic [2:0] MODE_EXC    = 3'b110;

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  logic             push_en;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] pc_plus_step;
  logic [PTR_W-1:0] top_idx;
  logic             ras_is_empty;
  logic             ras_is_full;

  assign pc_plus_step = pc_q + STEP_W;
  assign top_idx      = wp_q - PTR_W'(1);
  assign ras_is_empty = (count_q == '0);
  assign ras_is_full  = (count_q == CNT_FULL);

  always_comb begin
    pc_d      = pc_q;
    wp_d      = wp_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;
    push_data = pc_plus_step;

    if (bus.ena) begin
      unique case (bus.mode)
        MODE_HOLD: ;
        MODE_INC:    pc_d = pc_plus_step;
        MODE_BRANCH: pc_d = pc_q + bus.data_in;
        MODE_JUMP:   pc_d = bus.data_in;
        MODE_CALL: begin
          // When full the write lands on the oldest slot, so the stack keeps
          // the most recent RAS_DEPTH return addresses.
          push_en = 1'b1;
          wp_d    = wp_q + PTR_W'(1);
          pc_d    = bus.data_in;
          if (ras_is_full) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        MODE_RET: begin
          if (ras_is_empty) begin
            pc_d  = EXC_VEC;
            unf_d = 1'b1;
          end else begin
            wp_d    = top_idx;
            count_d = count_q - CNT_W'(1);
            pc_d    = ras_mem_q[top_idx];
          end
        end
        MODE_EXC:    pc_d = EXC_VEC;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      wp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents carry no reset; only the write is blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      ras_mem_q[wp_q] <= push_data;
    end
  end

  assign bus.data_out  = pc_q;
  assign bus.ras_count = count_q;
  assign bus.ras_empty = ras_is_empty;
  assign bus.ras_full  = ras_is_full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: vector table for the main sequences, then
// hand-written reset-priority and EXC/reserved sequences.
module tb_pc_seq_unit;
  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, BRA = 3'b010, JMP = 3'b011;
  localparam logic [2:0] CALL = 3'b100, RET = 3'b101, EXC = 3'b110, RSV = 3'b111;

  typedef struct {
    logic        rst;
    logic        ena;
    logic [2:0]  mode;
    logic [31:0] din;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t tbl [$];

  pc_seq_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

  pc_seq_unit #(
    .WIDTH(32), .RESET_VEC(32'h0), .EXC_VEC(32'h4), .STEP(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic [31:0] d,
                              logic [31:0] pc, logic [2:0] cnt,
                              logic ovf, logic unf);
    vec_t v;
    v.rst = r;  v.ena = e;  v.mode = m;  v.din = d;
    v.pc  = pc; v.cnt = cnt;
    v.emp = (cnt == 3'd0);
    v.ful = (cnt == 3'd4);
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [39:0] act, exp;
    rst         = v.rst;
    bus.ena     = v.ena;
    bus.mode    = v.mode;
    bus.data_in = v.din;
    @(posedge clk);
    #1;
    act = {bus.data_out, bus.ras_count, bus.ras_empty, bus.ras_full,
           bus.ras_ovf, bus.ras_unf};
    exp = {v.pc, v.cnt, v.emp, v.ful, v.ovf, v.unf};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got pc=%h cnt=%0d e=%b f=%b o=%b u=%b, want pc=%h cnt=%0d e=%b f=%b o=%b u=%b",
               name, bus.data_out, bus.ras_count, bus.ras_empty, bus.ras_full,
               bus.ras_ovf, bus.ras_unf, v.pc, v.cnt, v.emp, v.ful, v.ovf, v.unf);
    end
  endtask

  initial begin
    rst = 1'b1; bus.ena = 1'b0; bus.mode = HOLD; bus.data_in = '0;

    tbl.push_back(mk(1, 0, HOLD, 32'h0,        32'h0,        3'd0, 0, 0));
    tbl.push_back(mk(1, 1, INC,  32'h0,        32'h0,        3'd0, 0, 0));
    tbl.push_back(mk(0, 0, INC,  32'h0,        32'h0,        3'd0, 0, 0));
    tbl.push_back(mk(0, 0, INC,  32'h0,        32'h0,        3'd0, 0, 0));
    tbl.push_back(mk(0, 0, INC,  32'h0,        32'h0,        3'd0, 0, 0));
    tbl.push_back(mk(0, 1, INC,  32'h0,        32'h4,        3'd0, 0, 0));
    tbl.push_back(mk(0, 1, INC,  32'h0,        32'h8,        3'd0, 0, 0));
    tbl.push_back(mk(0, 1, INC,  32'h0,        32'hC,        3'd0, 0, 0));
    tbl.push_back(mk(0, 1, BRA,  32'hFFFFFFF8, 32'h4,        3'd0, 0, 0));
    tbl.push_back(mk(0, 1, JMP,  32'hFFFFFFFC, 32'hFFFFFFFC, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, INC,  32'h0,        32'h0,        3'd0, 0, 0));
    tbl.push_back(mk(0, 1, JMP,  32'h10,       32'h10,       3'd0, 0, 0));
    tbl.push_back(mk(0, 1, CALL, 32'h100,      32'h100,      3'd1, 0, 0));
    tbl.push_back(mk(0, 0, CALL, 32'h999,      32'h100,      3'd1, 0, 0));
    tbl.push_back(mk(0, 1, RET,  32'h0,        32'h14,       3'd0, 0, 0));
    tbl.push_back(mk(0, 1, JMP,  32'h0,        32'h0,        3'd0, 0, 0));
    tbl.push_back(mk(0, 1, CALL, 32'h100,      32'h100,      3'd1, 0, 0));
    tbl.push_back(mk(0, 1, CALL, 32'h200,      32'h200,      3'd2, 0, 0));
    tbl.push_back(mk(0, 1, CALL, 32'h300,      32'h300,      3'd3, 0, 0));
    tbl.push_back(mk(0, 1, CALL, 32'h400,      32'h400,      3'd4, 0, 0));
    tbl.push_back(mk(0, 1, CALL, 32'h500,      32'h500,      3'd4, 1, 0));
    tbl.push_back(mk(0, 1, RET,  32'h0,        32'h404,      3'd3, 1, 0));
    tbl.push_back(mk(0, 1, RET,  32'h0,        32'h304,      3'd2, 1, 0));
    tbl.push_back(mk(0, 1, RET,  32'h0,        32'h204,      3'd1, 1, 0));
    tbl.push_back(mk(0, 1, RET,  32'h0,        32'h104,      3'd0, 1, 0));
    tbl.push_back(mk(0, 1, RET,  32'h0,        32'h4,        3'd0, 1, 1));
    tbl.push_back(mk(0, 1, HOLD, 32'h0,        32'h4,        3'd0, 1, 1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Reset priority: stack holds two entries with ovf set, then rst with CALL.
    apply(mk(1, 0, HOLD, 32'h0,   32'h0,   3'd0, 0, 0), "rp_reset");
    apply(mk(0, 1, CALL, 32'h100, 32'h100, 3'd1, 0, 0), "rp_call1");
    apply(mk(0, 1, CALL, 32'h200, 32'h200, 3'd2, 0, 0), "rp_call2");
    apply(mk(0, 1, CALL, 32'h300, 32'h300, 3'd3, 0, 0), "rp_call3");
    apply(mk(0, 1, CALL, 32'h400, 32'h400, 3'd4, 0, 0), "rp_call4");
    apply(mk(0, 1, CALL, 32'h500, 32'h500, 3'd4, 1, 0), "rp_call5");
    apply(mk(0, 1, RET,  32'h0,   32'h404, 3'd3, 1, 0), "rp_ret1");
    apply(mk(0, 1, RET,  32'h0,   32'h304, 3'd2, 1, 0), "rp_ret2");
    apply(mk(1, 1, CALL, 32'h800, 32'h0,   3'd0, 0, 0), "rp_rst_call");
    apply(mk(0, 1, RET,  32'h0,   32'h4,   3'd0, 0, 1), "rp_ret_empty");

    // EXC leaves the stack alone; reserved mode holds.
    apply(mk(1, 0, HOLD, 32'h0,  32'h0,  3'd0, 0, 0), "ex_reset");
    apply(mk(0, 1, JMP,  32'h40, 32'h40, 3'd0, 0, 0), "ex_jmp");
    apply(mk(0, 1, CALL, 32'h40, 32'h40, 3'd1, 0, 0), "ex_call");
    apply(mk(0, 1, EXC,  32'h0,  32'h4,  3'd1, 0, 0), "ex_exc");
    apply(mk(0, 1, RSV,  32'h0,  32'h4,  3'd1, 0, 0), "ex_rsv1");
    apply(mk(0, 1, RSV,  32'h0,  32'h4,  3'd1, 0, 0), "ex_rsv2");
    apply(mk(0, 1, RET,  32'h0,  32'h44, 3'd0, 0, 0), "ex_ret");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised program-counter sequencer. Successor to the plain PC register: it adds next-PC generation (increment, relative branch, absolute jump, exception vector) and a circular return-address stack (RAS) for call/return. It sits at the head of the fetch stage. data_out drives the instruction-memory address, and the decode stage drives the mode and target.

Parameters:
WIDTH, 32, PC width in bits
RESET_VEC, 0x0000_0000, PC value loaded on reset (WIDTH bits)
EXC_VEC, 0x0000_0004, PC value loaded on EXC mode and on RAS underflow
STEP, 4, sequential increment added to PC
RAS_DEPTH, 4, return-address stack entries; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high; highest priority, overrides ena
ena  in  1  update enable; when low, PC and RAS hold
mode  in  3  next-PC operation select (see Behaviour)
data_in  in  WIDTH  branch offset (two's complement) or absolute target
data_out  out  WIDTH  current PC (registered)
ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries
ras_empty  out  1  ras_count == 0
ras_full  out  1  ras_count == RAS_DEPTH
ras_ovf  out  1  sticky: a CALL occurred while full
ras_unf  out  1  sticky: a RET occurred while empty

Behaviour:
- Reset (rst=1 at rising edge, any ena/mode) sets the following:
  - data_out=RESET_VEC
  - ras_count=0, RAS pointer=0
  - ras_ovf=0, ras_unf=0
  - RAS contents are don't-care
- ras_empty and ras_full are combinational from ras_count. After reset, empty=1 and full=0.
- Latency: one cycle. The operation sampled at edge N is visible on data_out after edge N. There is no combinational path from inputs to data_out.
- ena=0: all state holds and mode is ignored.
- ena=1, mode decode:
  - 000 HOLD: no change.
  - 001 INC: pc <= pc + STEP.
  - 010 BRANCH: pc <= pc + data_in.
  - 011 JUMP: pc <= data_in.
  - 100 CALL: push (pc + STEP), then pc <= data_in.
  - 101 RET: pop top entry, then pc <= popped value.
  - 110 EXC: pc <= EXC_VEC; RAS unchanged.
  - 111 reserved: identical to HOLD.
- Arithmetic: all additions are modulo 2^WIDTH. Carry out is discarded and there is no alignment masking.
- RAS is a circular buffer. Write pointer wp points to the next free slot; top entry = slot wp-1 (mod RAS_DEPTH).
- CALL when not full: write slot wp, wp++, count++.
- CALL when full:
  - write slot wp, overwriting the oldest entry; wp++.
  - count stays at RAS_DEPTH; ras_ovf <= 1.
- RET when not empty: wp--, count--, pc <= entry at new wp.
- RET when empty:
  - pc <= EXC_VEC; ras_unf <= 1.
  - wp and count unchanged.
- Pointer wrap: wp is $clog2(RAS_DEPTH) bits and wraps naturally.
- ras_ovf and ras_unf clear only on reset.
- Reset mid-operation: rst=1 together with ena=1 and any mode performs reset only. No push or pop occurs.

Test Plan:
(Defaults WIDTH=32, STEP=4, RAS_DEPTH=4, EXC_VEC=0x4)
1. Reset and hold:
   - rst=1 for 2 cycles -> data_out=0x0, ras_empty=1, ras_count=0.
   - Release, ena=0, mode=001 for 3 cycles -> data_out stays 0x0.
2. Arithmetic and wrap:
   - ena=1, INC x3 -> 0xC.
   - BRANCH data_in=0xFFFF_FFF8 -> 0x4.
   - JUMP data_in=0xFFFF_FFFC -> 0xFFFF_FFFC.
   - INC -> 0x0 (wrap).
3. Single call/return:
   - JUMP 0x10, then CALL data_in=0x100 -> data_out=0x100, ras_count=1.
   - RET -> data_out=0x14, ras_empty=1.
4. Overflow and underflow:
   - From pc=0x0, CALL to 0x100, 0x200, 0x300, 0x400 -> ras_full=1 after the 4th CALL.
   - CALL 0x500 -> ras_ovf=1, ras_count=4.
   - RET x4 -> pc sequence 0x404, 0x304, 0x204, 0x104.
   - 5th RET -> pc=0x4 (EXC_VEC), ras_unf=1, ras_count=0.
5. Reset priority:
   - With ras_count=2 and ras_ovf=1, drive rst=1, ena=1, mode=CALL, data_in=0x800.
   - -> data_out=0x0, ras_count=0, ras_ovf=0, ras_unf=0; no push.
6. EXC and reserved:
   - From pc=0x40 with ras_count=1, EXC -> pc=0x4, ras_count=1.
   - mode=111 for 2 cycles -> pc stays 0x4.
   - RET -> pc=0x44.
